// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with optional
// write-to-read bypass and optional hardwired-zero r0. It also provides a
// registered debug window with modulo wrap and a sequential clear engine that
// zeroes one entry per cycle after reset or on request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zeroing mem[idx], idx counts 0..DEPTH-1; user writes dropped
// S_IDLE  | normal operation; clr restarts the clear engine
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 3,
   parameter int WIN        = 8,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   output logic                         busy,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd,
   input  logic                         we,
   input  logic [ADDR_WIDTH-1:0]        wa,
   input  logic [DATA_WIDTH-1:0]        wd,
   input  logic [ADDR_WIDTH-1:0]        dbg_base,
   output logic [WIN*DATA_WIDTH-1:0]    dbg_win
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] IDX_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH+1)'(1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH:0]   idx, idx_nx;
   logic                  clr_we;
   logic                  user_we;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Clear-engine state register; reset parks the engine at the start of a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_CLEAR;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   // Next-state logic; a clr during an active clear restarts it without writing.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      clr_we   = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr) begin
               state_nx = S_CLEAR;
               idx_nx   = '0;
            end
         end
         S_CLEAR: begin
            if (clr) begin
               idx_nx = '0;
            end else begin
               clr_we = 1'b1;
               idx_nx = idx + IDX_ONE;
               if (idx == IDX_LAST) state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_CLEAR;
            idx_nx   = '0;
         end
      endcase
   end

   assign busy    = (state == S_CLEAR);
   assign user_we = we && !busy && !((ZERO_REG != 0) && (wa == '0));

   // Storage array; not reset directly, the clear engine zeroes it.
   // clr_we implies busy, so the two write sources never collide.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we)       mem[idx[ADDR_WIDTH-1:0]] <= '0;
         else if (user_we) mem[wa] <= wd;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra_i;
      assign ra_i = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd[i*DATA_WIDTH +: DATA_WIDTH] =
         busy                                    ? '0 :
         ((ZERO_REG != 0) && (ra_i == '0))       ? '0 :
         ((BYPASS != 0) && we && (wa == ra_i))   ? wd :
                                                   mem[ra_i];
   end

   for (genvar j = 0; j < WIN; j++) begin : g_win
      logic [ADDR_WIDTH-1:0] da;
      logic [DATA_WIDTH-1:0] slot_q;
      assign da = dbg_base + ADDR_WIDTH'(j);

      // Debug slot register: no bypass, blanked while clearing and for hardwired r0.
      always_ff @(posedge clk) begin
         if (!rst_n)                               slot_q <= '0;
         else if (busy)                            slot_q <= '0;
         else if ((ZERO_REG != 0) && (da == '0))   slot_q <= '0;
         else                                      slot_q <= mem[da];
      end

      assign dbg_win[j*DATA_WIDTH +: DATA_WIDTH] = slot_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with default parameters
// (32x32, 3 read ports, window 8, ZERO_REG=1, BYPASS=1).
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;
   localparam int W  = 8;
   localparam int D  = 32;

   logic            clk = 1'b0;
   logic            rst_n, clr, we;
   logic            busy;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;
   logic [AW-1:0]   wa, dbg_base;
   logic [DW-1:0]   wd;
   logic [W*DW-1:0] dbg_win;

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
      .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
      .dbg_base(dbg_base), .dbg_win(dbg_win)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            busy;
      logic [NR*DW-1:0] rd;
      logic [W*DW-1:0] dbg;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: register contents plus number of clear cycles left.
   logic [DW-1:0]   mdl [D];
   int              clr_left;
   logic [W*DW-1:0] dbg_m;

   task automatic chk(input string name, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every sampled cycle pops one expected response and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("busy", W*DW'(busy), W*DW'(e.busy));
            for (int i = 0; i < NR; i++)
               chk($sformatf("rd%0d", i), W*DW'(rd[i*DW +: DW]), W*DW'(e.rd[i*DW +: DW]));
            chk("dbg_win", dbg_win, e.dbg);
         end
      end
   end

   task automatic step(input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [AW-1:0] base);
      exp_t            e;
      logic [AW-1:0]   rr [NR];
      logic            mbusy;
      logic [W*DW-1:0] dnext;
      int              sa;
      rst_n = r; clr = c; we = w; wa = a; wd = d; dbg_base = base;
      ra = {r2, r1, r0};
      rr[0] = r0; rr[1] = r1; rr[2] = r2;
      mbusy = (clr_left > 0);
      e.busy = mbusy;
      e.dbg  = dbg_m;
      for (int i = 0; i < NR; i++) begin
         if (mbusy || rr[i] == 0)      e.rd[i*DW +: DW] = '0;
         else if (w && a == rr[i])     e.rd[i*DW +: DW] = d;
         else                          e.rd[i*DW +: DW] = mdl[rr[i]];
      end
      sb.push_back(e);
      for (int j = 0; j < W; j++) begin
         sa = (int'(base) + j) % D;
         dnext[j*DW +: DW] = (mbusy || sa == 0) ? '0 : mdl[sa];
      end
      @(posedge clk);
      if (!r) begin
         clr_left = D;
         dbg_m    = '0;
      end else begin
         dbg_m = dnext;
         if (mbusy) begin
            if (c) clr_left = D;
            else begin
               clr_left--;
               if (clr_left == 0)
                  for (int k = 0; k < D; k++) mdl[k] = '0;
            end
         end else begin
            if (w && a != 0) mdl[a] = d;
            if (c) clr_left = D;
         end
      end
      #1;
   endtask

   task automatic nop(input int n);
      for (int k = 0; k < n; k++)
         step(1'b1, 1'b0, 1'b0, AW'($urandom), DW'($urandom),
              AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] a;
      rst_n = 1'b0; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; dbg_base = '0;
      for (int k = 0; k < D; k++) mdl[k] = 'x;
      repeat (2) @(posedge clk);
      #1;
      clr_left = D;
      dbg_m    = '0;

      // Reset held one more cycle, then the full clear.
      step(1'b0, 0, 0, 0, 0, 1, 2, 3, 0);
      nop(D + 2);

      // Bypass of r5 on ports 0 and 1, then registered read-back.
      step(1'b1, 0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0);
      step(1'b1, 0, 0, 0, 0, 5, 5, 5, 0);

      // Hardwired-zero r0.
      step(1'b1, 0, 1, 0, 32'h12345678, 0, 0, 5, 0);
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Debug window wrap at base 30.
      step(1'b1, 0, 1, 30, 32'h1E, 0, 0, 0, 0);
      step(1'b1, 0, 1, 31, 32'h1F, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) step(1'b1, 0, 1, AW'(k), DW'(k), 0, 0, 0, 0);
      step(1'b1, 0, 0, 0, 0, 30, 31, 3, 30);
      step(1'b1, 0, 0, 0, 0, 30, 31, 3, 30);
      step(1'b1, 0, 0, 0, 0, 30, 31, 3, 30);

      // clr with a simultaneous write, then a dropped write while busy.
      step(1'b1, 1, 1, 3, 32'hAA, 3, 4, 0, 0);
      step(1'b1, 0, 1, 4, 32'hBB, 3, 4, 0, 0);
      nop(D);
      step(1'b1, 0, 0, 0, 0, 3, 4, 30, 0);

      // Restart by clr at idx 10, then by reset at idx 20.
      step(1'b1, 1, 0, 0, 0, 1, 2, 3, 0);
      nop(10);
      step(1'b1, 1, 0, 0, 0, 1, 2, 3, 0);
      nop(20);
      step(1'b0, 0, 0, 0, 0, 1, 2, 3, 0);
      nop(D + 2);

      // Randomized traffic with occasional clr and reset.
      for (int k = 0; k < 600; k++) begin
         a = AW'($urandom);
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 63) == 0),
              1'($urandom), a, DW'($urandom),
              ($urandom_range(0, 2) == 0) ? a : AW'($urandom),
              ($urandom_range(0, 2) == 0) ? a : AW'($urandom),
              AW'($urandom), AW'($urandom));
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
